// File: rtl/step_sched_pkg.sv
// rtl/step_sched_pkg.sv - shared types and helpers for the step chunk scheduler
//
// Contents:
//   sched_state_e : scheduler states (IDLE, DIR_SETUP, TRIGGER, RUN, FINISH)
//   max_chunk_of  : largest chunk a pulse_num field of the given width can carry
//   chunk_of      : min(remaining, max_chunk)
package step_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DIR_SETUP = 3'd1,
    TRIGGER   = 3'd2,
    RUN       = 3'd3,
    FINISH    = 3'd4
  } sched_state_e;

  function automatic int max_chunk_of(input int pulse_num_bits);
    return (1 << pulse_num_bits) - 1;
  endfunction

  function automatic logic [31:0] chunk_of(input logic [31:0] remaining,
                                           input logic [31:0] max_chunk);
    return (remaining < max_chunk) ? remaining : max_chunk;
  endfunction

endpackage

// File: rtl/step_chunk_scheduler_fsm.sv
// rtl/step_chunk_scheduler_fsm.sv - state register, next-state logic and control strobes
//
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   clk_en            : logic clock enable shared with the pulse generator
//   cmd_valid         : command offered (acted on only in IDLE)
//   cmd_null          : offered command has zero steps or zero width
//   cmd_dir_change    : offered command direction differs from current DIR
//   setup_last        : DIR setup counter is on its final tick
//   pg_rdy, pg_done   : pulse generator handshake
//   abort_now         : abort input or sticky abort already pending
//   remaining_zero    : no steps left after the current chunk
//   state             : current state
//   cmd_ready, busy, done, pg_trigger : registered-state decoded outputs
//   accept            : command accepted this cycle
//   trig_accept       : generator takes the trigger this cycle
//   chunk_done        : running chunk completes this cycle
//   load_chunk        : entering TRIGGER; datapath registers the next chunk size
//   enter_setup       : entering DIR_SETUP; datapath updates DIR
//   enter_finish      : entering FINISH; datapath captures the aborted flag
module step_chunk_scheduler_fsm
  import step_sched_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_en,
  input  logic         cmd_valid,
  input  logic         cmd_null,
  input  logic         cmd_dir_change,
  input  logic         setup_last,
  input  logic         pg_rdy,
  input  logic         pg_done,
  input  logic         abort_now,
  input  logic         remaining_zero,
  output sched_state_e state,
  output logic         cmd_ready,
  output logic         busy,
  output logic         done,
  output logic         pg_trigger,
  output logic         accept,
  output logic         trig_accept,
  output logic         chunk_done,
  output logic         load_chunk,
  output logic         enter_setup,
  output logic         enter_finish
);

  sched_state_e next_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    pg_trigger  = 1'b0;
    accept      = 1'b0;
    trig_accept = 1'b0;
    chunk_done  = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_null) begin
            next_state = FINISH;
          end else if (cmd_dir_change) begin
            next_state = DIR_SETUP;
          end else begin
            next_state = TRIGGER;
          end
        end
      end
      DIR_SETUP: begin
        busy = 1'b1;
        if (abort_now) begin
          next_state = FINISH;
        end else if (clk_en && setup_last) begin
          next_state = TRIGGER;
        end
      end
      TRIGGER: begin
        busy       = 1'b1;
        pg_trigger = 1'b1;
        // Acceptance wins over abort: a chunk the generator has taken must run.
        if (clk_en && pg_rdy) begin
          trig_accept = 1'b1;
          next_state  = RUN;
        end else if (abort_now) begin
          next_state = FINISH;
        end
      end
      RUN: begin
        busy = 1'b1;
        // RUN is entered the edge after acceptance, so any pg_done seen here
        // belongs to the running chunk.
        if (clk_en && pg_done) begin
          chunk_done = 1'b1;
          next_state = (remaining_zero || abort_now) ? FINISH : TRIGGER;
        end
      end
      FINISH: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    load_chunk   = (next_state == TRIGGER) && (state != TRIGGER);
    enter_setup  = (next_state == DIR_SETUP) && (state != DIR_SETUP);
    enter_finish = (next_state == FINISH) && (state != FINISH);
  end

endmodule

// File: rtl/step_chunk_scheduler.sv
// rtl/step_chunk_scheduler.sv - splits axis moves into pulse generator chunks with DIR setup
//
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   clk_en                        : logic clock enable shared with the pulse generator
//   cmd_valid / cmd_ready         : move command handshake
//   cmd_steps, cmd_dir, cmd_width : total steps, direction, pulse width in clk_en ticks
//   abort                         : stop after the current chunk
//   pg_pulse_num, pg_pulse_width  : chunk size and pulse width for the generator
//   pg_trigger / pg_rdy           : trigger handshake to the generator
//   pg_done                       : generator finished the chunk
//   dir                           : stepper DIR line
//   busy, done, aborted           : command status; aborted qualifies done
//   steps_issued                  : steps completed for the current or last command
module step_chunk_scheduler
  import step_sched_pkg::*;
#(
  parameter int STEPS_BITS       = 16,
  parameter int PULSE_NUM_BITS   = 8,
  parameter int PULSE_WIDTH_BITS = 8,
  parameter int DIR_SETUP_TICKS  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_en,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [STEPS_BITS-1:0]       cmd_steps,
  input  logic                        cmd_dir,
  input  logic [PULSE_WIDTH_BITS-1:0] cmd_width,
  input  logic                        abort,
  output logic [PULSE_NUM_BITS-1:0]   pg_pulse_num,
  output logic [PULSE_WIDTH_BITS-1:0] pg_pulse_width,
  output logic                        pg_trigger,
  input  logic                        pg_done,
  input  logic                        pg_rdy,
  output logic                        dir,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted,
  output logic [STEPS_BITS-1:0]       steps_issued
);

  localparam int MAX_CHUNK = max_chunk_of(PULSE_NUM_BITS);
  localparam int SETUP_W   = $clog2(DIR_SETUP_TICKS + 1);

  sched_state_e                state;
  logic [STEPS_BITS-1:0]       remaining;
  logic [SETUP_W-1:0]          setup_cnt;
  logic                        abort_pending;
  logic                        abort_now;
  logic                        accept;
  logic                        trig_accept;
  logic                        chunk_done;
  logic                        load_chunk;
  logic                        enter_setup;
  logic                        enter_finish;
  logic                        cmd_null;
  logic                        cmd_dir_change;
  logic                        setup_last;
  logic                        remaining_zero;
  logic [STEPS_BITS-1:0]       chunk_src;
  logic [PULSE_NUM_BITS-1:0]   next_chunk;
  logic [STEPS_BITS-1:0]       chunk_ext;

  assign cmd_null       = (cmd_steps == '0) || (cmd_width == '0);
  assign cmd_dir_change = (cmd_dir != dir);
  assign setup_last     = (setup_cnt == SETUP_W'(DIR_SETUP_TICKS - 1));
  assign remaining_zero = (remaining == '0);
  assign abort_now      = abort || abort_pending;

  // The first chunk of a move is sized from the command itself because
  // remaining is only loaded on the same edge.
  assign chunk_src  = (state == IDLE) ? cmd_steps : remaining;
  assign next_chunk = PULSE_NUM_BITS'(chunk_of(32'(chunk_src), 32'(MAX_CHUNK)));
  assign chunk_ext  = STEPS_BITS'(pg_pulse_num);

  step_chunk_scheduler_fsm u_fsm (
    .clk            (clk),
    .reset          (reset),
    .clk_en         (clk_en),
    .cmd_valid      (cmd_valid),
    .cmd_null       (cmd_null),
    .cmd_dir_change (cmd_dir_change),
    .setup_last     (setup_last),
    .pg_rdy         (pg_rdy),
    .pg_done        (pg_done),
    .abort_now      (abort_now),
    .remaining_zero (remaining_zero),
    .state          (state),
    .cmd_ready      (cmd_ready),
    .busy           (busy),
    .done           (done),
    .pg_trigger     (pg_trigger),
    .accept         (accept),
    .trig_accept    (trig_accept),
    .chunk_done     (chunk_done),
    .load_chunk     (load_chunk),
    .enter_setup    (enter_setup),
    .enter_finish   (enter_finish)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining      <= '0;
      setup_cnt      <= '0;
      abort_pending  <= 1'b0;
      aborted        <= 1'b0;
      dir            <= 1'b0;
      pg_pulse_num   <= '0;
      pg_pulse_width <= '0;
      steps_issued   <= '0;
    end else begin
      if (accept) begin
        remaining      <= cmd_steps;
        pg_pulse_width <= cmd_width;
        steps_issued   <= '0;
        abort_pending  <= 1'b0;
        aborted        <= 1'b0;
        setup_cnt      <= '0;
      end else begin
        if (busy && abort) begin
          abort_pending <= 1'b1;
        end
        if (enter_finish) begin
          aborted <= abort_now;
        end
        if ((state == DIR_SETUP) && clk_en) begin
          setup_cnt <= setup_cnt + 1'b1;
        end
        if (trig_accept) begin
          remaining <= remaining - chunk_ext;
        end
        if (chunk_done) begin
          steps_issued <= steps_issued + chunk_ext;
        end
      end

      if (enter_setup) begin
        dir <= cmd_dir;
      end
      if (load_chunk) begin
        pg_pulse_num <= next_chunk;
      end
    end
  end

endmodule
